// File: rtl/ula_seq_param.sv
// ---------------------------------------------------------------------------
// ula_seq_param -- registered, width-generic ALU with an iterative unsigned
// shift-add multiplier.
//
// One operation is in flight at a time. ADD/SUB/XOR/AND/OR and the reserved
// opcodes finish one cycle after accept. MUL takes WIDTH iterations in CALC.
// The result is held in DONE until the consumer takes it.
//
// Optional feature macro: ULA_FLAGS_EN
//   When defined, adds the registered flag outputs zero, neg and ovf. They
//   are valid together with out_valid and reset to 0.
//   When undefined, the flag ports and their logic do not exist.
//
// Parameters
//   WIDTH      operand width in bits (>= 2); the result bus is 2*WIDTH wide
//
// Ports
//   clk        clock; all logic is on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands/op valid
//   in_ready   block can accept an op (high only in IDLE)
//   a, b       operands, WIDTH bits
//   op         000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR, 101 MUL,
//              110/111 reserved (result 0)
//   cin        carry in, used by ADD/SUB only
//   out_valid  result valid (DONE state)
//   out_ready  consumer takes the result
//   f          result, 2*WIDTH bits; non-MUL results are zero-extended
//   cout       carry out for ADD/SUB, otherwise 0
//   zero/neg/ovf   status flags (only with ULA_FLAGS_EN)
// ---------------------------------------------------------------------------
module ula_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           op,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   f,
    output logic                 cout
`ifdef ULA_FLAGS_EN
    ,
    output logic                 zero,
    output logic                 neg,
    output logic                 ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   f_q, f_d;
    logic                 cout_q, cout_d;
`ifdef ULA_FLAGS_EN
    logic                 zero_q, zero_d;
    logic                 neg_q, neg_d;
    logic                 ovf_q, ovf_d;
`endif

    // Single-cycle datapath. SUB is a + ~b + cin, so cin=1 gives a-b and
    // cout=1 means no borrow.
    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH:0]       addsub;
    logic [WIDTH-1:0]     res_f;
    logic                 res_cout;
    logic                 res_ovf;

    always_comb begin
        b_eff    = (op == OP_SUB) ? ~b : b;
        addsub   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        res_f    = '0;
        res_cout = 1'b0;
        res_ovf  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res_f    = addsub[WIDTH-1:0];
                res_cout = addsub[WIDTH];
                // Signed overflow: both addends share a sign that differs
                // from the sign of the sum.
                res_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (addsub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR:  res_f = a ^ b;
            OP_AND:  res_f = a & b;
            OP_OR:   res_f = a | b;
            default: res_f = '0;
        endcase
    end

    // One shift-add step. The upper part acc[2W:W] gets the multiplicand
    // added when the current multiplier LSB is set, and then the whole
    // accumulator shifts right by one. The upper part is at most WIDTH
    // significant bits before the add, so the WIDTH+1-bit sum cannot overflow.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH:0]     acc_step;

    always_comb begin
        mul_sum  = acc_q[2*WIDTH:WIDTH] +
                   {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
        acc_step = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    end

    // Next-state and datapath register control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        f_d     = f_q;
        cout_d  = cout_q;
`ifdef ULA_FLAGS_EN
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        // The multiplier sits in the low half and is consumed
                        // LSB-first as the accumulator shifts.
                        acc_d   = {{(WIDTH+1){1'b0}}, b};
                        mcand_d = a;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end else begin
                        f_d     = {{WIDTH{1'b0}}, res_f};
                        cout_d  = res_cout;
`ifdef ULA_FLAGS_EN
                        zero_d  = (res_f == '0);
                        neg_d   = res_f[WIDTH-1];
                        ovf_d   = res_ovf;
`endif
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    f_d     = acc_step[2*WIDTH-1:0];
                    cout_d  = 1'b0;
`ifdef ULA_FLAGS_EN
                    zero_d  = (acc_step[2*WIDTH-1:0] == '0);
                    neg_d   = acc_step[2*WIDTH-1];
                    ovf_d   = 1'b0;
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // No new accept here, even with out_ready high: the block
                // returns to IDLE first.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            f_q     <= '0;
            cout_q  <= 1'b0;
`ifdef ULA_FLAGS_EN
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
`ifdef ULA_FLAGS_EN
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign f         = f_q;
    assign cout      = cout_q;
`ifdef ULA_FLAGS_EN
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
`endif

endmodule
